// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte-stream requesters. Requesters
// win the transmitter in round-robin order and keep it for a whole packet
// (until a byte flagged last is taken), so messages never interleave. An owner
// that stops offering bytes mid-packet is released after LOCK_TIMEOUT cycles.
//
// Handshakes:
//   requester side: i_req[k] with i_data/i_last is held until o_ack[k]; the
//     byte is taken in the cycle o_ack[k] is high. Dropping i_req[k] earlier
//     withdraws the byte, and nothing is taken.
//   transmitter side: a byte is written (o_wr for one cycle, o_data valid and
//     held afterwards) only when i_txe was seen high. i_txe is ignored for
//     HOLDOFF cycles after each write to cover the transmitter's flag lag.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int HOLDOFF      = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [8*N_REQ-1:0]   i_data,
   input  logic [N_REQ-1:0]     i_last,
   output logic [N_REQ-1:0]     o_ack,
   output logic [N_REQ-1:0]     o_grant,
   output logic                 o_timeout,
   output logic                 o_busy,
   input  logic                 i_txe,
   output logic                 o_wr,
   output logic [7:0]           o_data
);

   localparam int PW = $clog2(N_REQ);
   localparam int HW = $clog2(HOLDOFF);
   localparam int TW = $clog2(LOCK_TIMEOUT);

   localparam logic [PW-1:0] PTR_RESET = PW'(N_REQ - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic [PW-1:0]       r_ptr;       // last winner; also the current owner index
   logic                r_last;      // last flag of the byte just written
   logic [HW-1:0]       r_hold_cnt;
   logic [TW-1:0]       r_tmo_cnt;
   logic                r_wr;
   logic [7:0]          r_data;
   logic [N_REQ-1:0]    r_ack;
   logic [N_REQ-1:0]    r_grant;
   logic                r_timeout;
   logic                r_busy;

   logic [PW-1:0]       w_cand [N_REQ];
   logic                w_any_req;
   logic [PW-1:0]       w_pick;
   logic [N_REQ-1:0]    w_pick_onehot;
   logic                w_own_req;
   logic                w_own_last;
   logic [7:0]          w_own_data;

   // Candidate order for the search: pointer+1, pointer+2, ... wrapping at N_REQ
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_cand[i] = PW'((int'(r_ptr) + i + 1) % N_REQ);
      end
   end

   // Round-robin pick: first requesting candidate in search order
   always_comb begin
      w_any_req = 1'b0;
      w_pick    = r_ptr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!w_any_req && i_req[w_cand[i]]) begin
            w_any_req = 1'b1;
            w_pick    = w_cand[i];
         end
      end
   end

   assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

   // Select the owner's request, last flag and byte
   always_comb begin
      w_own_req  = 1'b0;
      w_own_last = 1'b0;
      w_own_data = 8'h00;
      for (int k = 0; k < N_REQ; k++) begin
         if (r_ptr == PW'(k)) begin
            w_own_req  = i_req[k];
            w_own_last = i_last[k];
            w_own_data = i_data[8*k +: 8];
         end
      end
   end

   // Arbitration / transmit FSM with all outputs registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= PTR_RESET;
         r_last     <= 1'b0;
         r_hold_cnt <= '0;
         r_tmo_cnt  <= '0;
         r_wr       <= 1'b0;
         r_data     <= 8'h00;
         r_ack      <= '0;
         r_grant    <= '0;
         r_timeout  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         // pulse outputs default low every cycle
         r_wr      <= 1'b0;
         r_ack     <= '0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tmo_cnt <= '0;
               if (w_any_req) begin
                  r_grant <= w_pick_onehot;
                  r_ptr   <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_txe && w_own_req) begin
                  r_wr       <= 1'b1;
                  r_ack      <= r_grant;
                  r_data     <= w_own_data;
                  r_last     <= w_own_last;
                  r_hold_cnt <= HOLD_LOAD;
                  r_tmo_cnt  <= '0;
                  r_state    <= ST_HOLD;
               end else if (!w_own_req) begin
                  // owner went quiet mid-packet: count toward forced release
                  if (r_tmo_cnt == TMO_LAST) begin
                     r_timeout <= 1'b1;
                     r_grant   <= '0;
                     r_busy    <= 1'b0;
                     r_tmo_cnt <= '0;
                     r_state   <= ST_IDLE;
                  end else if (r_tmo_cnt != '1) begin
                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  end
               end
               // request present but transmitter busy: counter holds
            end
            ST_HOLD: begin
               if (r_hold_cnt == '0) begin
                  if (r_last) begin
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_wr      = r_wr;
   assign o_data    = r_data;
   assign o_ack     = r_ack;
   assign o_grant   = r_grant;
   assign o_timeout = r_timeout;
   assign o_busy    = r_busy;

endmodule
